// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences pc/im/grf/alu/ext/dm over several clocks per instruction.
// Optional MC_CTRL_MEMWAIT_EN adds mem_ready so FETCH, MEM_RD and MEM_WR stall on slow memory.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
`ifdef MC_CTRL_MEMWAIT_EN
    input  logic        mem_ready,
`endif
    output logic        pc_we,
    output logic        ir_we,
    output logic [1:0]  npc_sel,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        ext_op,
    output logic        mem_we,
    output logic        instr_done,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_JUMP   = 3'd7
    } state_t;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic [1:0] npc_sel;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       ext_op;
        logic       mem_we;
        logic       instr_done;
        logic       illegal;
    } ctl_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    state_t cur, nxt;
    ctl_t   ctl;
    logic   mem_ok;

`ifdef MC_CTRL_MEMWAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    logic [5:0] opc, fn;
    logic is_r, is_nop, is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, is_jr;

    assign opc     = instr[31:26];
    assign fn      = instr[5:0];
    assign is_nop  = (instr == 32'd0);
    assign is_r    = (opc == 6'b000000);
    assign is_addu = is_r && (fn == 6'b100001);
    assign is_subu = is_r && (fn == 6'b100011);
    assign is_jr   = is_r && (fn == 6'b001000);
    assign is_ori  = (opc == 6'b001101);
    assign is_lui  = (opc == 6'b001111);
    assign is_lw   = (opc == 6'b100011);
    assign is_sw   = (opc == 6'b101011);
    assign is_beq  = (opc == 6'b000100);
    assign is_jal  = (opc == 6'b000011);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur <= S_FETCH;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        ctl = '0;
        // ALU controls are held from EXE through MEM/WB so the address/result stays stable
        if (cur == S_EXE || cur == S_MEM_RD || cur == S_MEM_WR || cur == S_WB) begin
            if (is_subu)              ctl.alu_op = ALU_SUB;
            else if (is_ori)          ctl.alu_op = ALU_OR;
            else if (is_lui)          ctl.alu_op = ALU_LUI;
            else                      ctl.alu_op = ALU_ADD;
            ctl.alu_src = is_ori || is_lui || is_lw || is_sw;
            ctl.ext_op  = is_lw || is_sw;
        end
        unique case (cur)
            S_FETCH: begin
                ctl.ir_we = mem_ok;
                ctl.pc_we = mem_ok;
                if (mem_ok) nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_nop) begin
                    ctl.instr_done = 1'b1;
                    nxt = S_FETCH;
                end else if (is_jal || is_jr) begin
                    nxt = S_JUMP;
                end else if (is_beq) begin
                    nxt = S_BRANCH;
                end else if (is_addu || is_subu || is_ori || is_lui || is_lw || is_sw) begin
                    nxt = S_EXE;
                end else begin
                    ctl.illegal    = 1'b1;
                    ctl.instr_done = 1'b1;
                    nxt = S_FETCH;
                end
            end
            S_EXE: begin
                if (is_lw)      nxt = S_MEM_RD;
                else if (is_sw) nxt = S_MEM_WR;
                else            nxt = S_WB;
            end
            S_MEM_RD: begin
                if (mem_ok) nxt = S_WB;
            end
            S_MEM_WR: begin
                ctl.mem_we = 1'b1;
                if (mem_ok) begin
                    ctl.instr_done = 1'b1;
                    nxt = S_FETCH;
                end
            end
            S_WB: begin
                ctl.reg_we     = 1'b1;
                ctl.reg_dst    = is_r ? 2'd1 : 2'd0;
                ctl.wd_sel     = is_lw ? 2'd1 : 2'd0;
                ctl.instr_done = 1'b1;
                nxt = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_op     = ALU_SUB;
                ctl.alu_src    = 1'b0;
                ctl.ext_op     = 1'b1;
                ctl.npc_sel    = 2'd1;
                ctl.pc_we      = zero;
                ctl.instr_done = 1'b1;
                nxt = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_we = 1'b1;
                if (is_jal) begin
                    ctl.npc_sel = 2'd2;
                    ctl.reg_we  = 1'b1;
                    ctl.reg_dst = 2'd2;
                    ctl.wd_sel  = 2'd2;
                end else begin
                    ctl.npc_sel = 2'd3;
                end
                ctl.instr_done = 1'b1;
                nxt = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
    end

    // Gate everything while reset is low so no write can slip through during abort
    assign pc_we      = reset & ctl.pc_we;
    assign ir_we      = reset & ctl.ir_we;
    assign npc_sel    = reset ? ctl.npc_sel : 2'd0;
    assign reg_we     = reset & ctl.reg_we;
    assign reg_dst    = reset ? ctl.reg_dst : 2'd0;
    assign wd_sel     = reset ? ctl.wd_sel : 2'd0;
    assign alu_src    = reset & ctl.alu_src;
    assign alu_op     = reset ? ctl.alu_op : 3'd0;
    assign ext_op     = reset & ctl.ext_op;
    assign mem_we     = reset & ctl.mem_we;
    assign instr_done = reset & ctl.instr_done;
    assign illegal    = reset & ctl.illegal;
    assign state      = reset ? cur : S_FETCH;

endmodule
